// File: rtl/ntt_modexp_engine.sv
// ntt_modexp_engine
// Sequential modular exponentiator: result = base^exp mod modulus.
// It uses left-to-right square-and-multiply. Each modular multiply is done by
// a bit-serial interleaved multiplier that consumes one multiplier bit per cycle,
// so one multiply takes W cycles. The engine holds one operation at a time.
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   rst_n     synchronous reset, active-low
//   in_valid  operand set valid
//   in_ready  engine idle and able to accept an operand set
//   base      base (base < modulus expected)
//   exp       exponent; all EXP_W bits are scanned from MSB to LSB
//   modulus   modulus (2 <= modulus expected)
//   out_valid result valid; held until out_ready
//   out_ready consumer accepts the result
//   result    base^exp mod modulus; registered

module ntt_modexp_engine #(
  parameter int unsigned W     = 64,
  parameter int unsigned EXP_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     base,
  input  logic [EXP_W-1:0] exp,
  input  logic [W-1:0]     modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned KW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {StIdle, StSqr, StMul, StDone} state_e;

  state_e           state_q;
  logic [W-1:0]     base_q;
  logic [W-1:0]     mod_q;
  logic [EXP_W-1:0] exp_q;
  logic [W-1:0]     r_q;
  logic [W:0]       acc_q;
  logic [CW-1:0]    bit_q;
  logic [KW-1:0]    k_q;

  // One step of the interleaved multiplier. The multiplier operand is always r.
  // The multiplicand is r when squaring and base when multiplying.
  logic [W-1:0] mul_b;
  logic [W:0]   mod_ext;
  logic [W:0]   dbl;
  logic [W:0]   red1;
  logic [W:0]   add;
  logic [W:0]   red2;
  logic         last_bit;

  always_comb begin
    mul_b    = (state_q == StMul) ? base_q : r_q;
    mod_ext  = {1'b0, mod_q};
    // acc < m < 2^W, so the top bit of acc is zero and the shift cannot overflow.
    dbl      = {acc_q[W-1:0], 1'b0};
    red1     = (dbl >= mod_ext) ? (dbl - mod_ext) : dbl;
    add      = r_q[bit_q] ? (red1 + {1'b0, mul_b}) : red1;
    red2     = (add >= mod_ext) ? (add - mod_ext) : add;
    last_bit = (bit_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      base_q    <= '0;
      mod_q     <= '0;
      exp_q     <= '0;
      r_q       <= '0;
      acc_q     <= '0;
      bit_q     <= '0;
      k_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            base_q   <= base;
            mod_q    <= modulus;
            exp_q    <= exp;
            r_q      <= W'(1);
            acc_q    <= '0;
            bit_q    <= CW'(W - 1);
            k_q      <= KW'(EXP_W - 1);
            in_ready <= 1'b0;
            state_q  <= StSqr;
          end
        end
        StSqr, StMul: begin
          acc_q <= red2;
          bit_q <= bit_q - CW'(1);
          if (last_bit) begin
            // The multiply is finished. r takes the product and acc is rearmed.
            acc_q <= '0;
            bit_q <= CW'(W - 1);
            r_q   <= red2[W-1:0];
            if (state_q == StSqr && exp_q[k_q]) begin
              state_q <= StMul;
            end else if (k_q == '0) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              result    <= red2[W-1:0];
            end else begin
              k_q     <= k_q - KW'(1);
              state_q <= StSqr;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_modexp_engine.sv
// Self-checking bench for ntt_modexp_engine. It runs directed cases and random
// operand sets. The expected results come from a right-to-left binary
// exponentiation that uses full-width products and the % operator.

module tb_ntt_modexp_engine;

  localparam int unsigned W     = 64;
  localparam int unsigned EXP_W = 64;
  localparam logic [63:0] P     = 64'd4179340454199820289;
  localparam logic [63:0] OMEGA = 64'd68630377364883;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     base;
  logic [EXP_W-1:0] exp;
  logic [W-1:0]     modulus;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;

  int unsigned n_checks;
  int unsigned n_errors;

  ntt_modexp_engine #(
    .W    (W),
    .EXP_W(EXP_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .base     (base),
    .exp      (exp),
    .modulus  (modulus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] e,
                                             input logic [63:0] m);
    logic [127:0] r;
    logic [127:0] sq;
    r  = 128'd1 % {64'd0, m};
    sq = {64'd0, b} % {64'd0, m};
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * sq) % {64'd0, m};
      sq = (sq * sq) % {64'd0, m};
    end
    return r[63:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from accept to output handshake. It checks the latency and
  // the result. With 'noise' set it pulses in_valid with junk while the engine is
  // busy. 'hold' is the number of cycles out_ready stays low after out_valid; the
  // result must stay stable over that time.
  task automatic run_op(input string tag, input logic [63:0] b, input logic [63:0] e,
                        input logic [63:0] m, input bit noise, input int hold);
    int          cycles;
    int          lat;
    logic [63:0] expv;
    bit          busy_ok;
    expv = ref_modexp(b, e, m);
    lat  = W * (EXP_W + $countones(e));
    check({tag, "_in_ready_idle"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    base     = b;
    exp      = e;
    modulus  = m;
    tick();
    in_valid = 1'b0;
    cycles   = 0;
    busy_ok  = 1'b1;
    while (!out_valid && cycles < 9000) begin
      if (noise && (cycles % 97 == 3)) begin
        in_valid = 1'b1;
        base     = 64'(m - 1);
        exp      = $urandom;
        modulus  = m;
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready) busy_ok = 1'b0;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, {63'd0, busy_ok}, 64'd1);
    check({tag, "_latency"}, 64'(cycles), 64'(lat));
    check({tag, "_result"}, result, expv);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_result"}, result, expv);
    end
    check({tag, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_in_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] rm;
    logic [63:0] rb;
    logic [63:0] re;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    base      = '0;
    exp       = '0;
    modulus   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);

    run_op("t1_3p5m7", 64'd3, 64'd5, 64'd7, 1'b0, 0);
    check("t1_value", result, 64'd5);
    run_op("t2_exp0", OMEGA, 64'd0, P, 1'b0, 0);
    run_op("t2_base0", 64'd0, 64'd9, P, 1'b0, 0);
    run_op("t3_root57", OMEGA, 64'd1 << 57, P, 1'b0, 0);
    run_op("t3_root56", OMEGA, 64'd1 << 56, P, 1'b0, 2);
    check("t3_root56_value", result, P - 64'd1);
    run_op("t4_allones", P - 64'd1, {64{1'b1}}, P, 1'b0, 0);
    run_op("t5_hold_noise", 64'd12345, 64'h0000_0000_00ff_0f0f, P, 1'b1, 20);
    run_op("bnd_b0e0", 64'd0, 64'd0, P, 1'b0, 0);

    // Reset in the middle of an operation.
    in_valid = 1'b1;
    base     = OMEGA;
    exp      = 64'd77;
    modulus  = P;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_in_ready", {63'd0, in_ready}, 64'd1);
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_result", result, 64'd0);
    run_op("t6_after", OMEGA, 64'd77, P, 1'b0, 0);

    for (int n = 0; n < 4; n++) begin
      rm = {$urandom, $urandom};
      if (rm < 64'd2) rm = 64'd2;
      rb = {$urandom, $urandom} % rm;
      re = {$urandom, $urandom};
      if (n == 1) re = re & 64'h0000_0000_0000_ffff;
      if (n == 2) rm = rm & 64'h0000_0000_0000_ffff | 64'd2;
      if (n == 2) rb = rb % rm;
      run_op("rand", rb, re, rm, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
